// File: rtl/tcu_wmma_uop_sequencer.sv
// Tensor-core WMMA micro-op sequencer.
// Takes one accepted WMMA instruction and walks the (m, n, k) step space,
// with k innermost and m outermost. For each step it emits one micro-op that
// carries the step indices, the A/B/C register numbers, the sub-block selects
// and the first-K / last flags.
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready=1
// ISSUE | presenting micro-ops, out_valid=1
module tcu_wmma_uop_sequencer #(
  parameter int M_STEPS      = 2,
  parameter int N_STEPS      = 4,
  parameter int K_STEPS      = 4,
  parameter int A_SUB_BLOCKS = 1,
  parameter int B_SUB_BLOCKS = 2,
  parameter int RA           = 0,
  parameter int RB           = 10,
  parameter int RC           = 24,
  parameter int NT           = 8,
  parameter int WID_W        = 2,
  localparam int MW  = (M_STEPS > 1) ? $clog2(M_STEPS) : 1,
  localparam int NW  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
  localparam int KW  = (K_STEPS > 1) ? $clog2(K_STEPS) : 1,
  localparam int SAW = (A_SUB_BLOCKS > 1) ? $clog2(A_SUB_BLOCKS) : 1,
  localparam int SBW = (B_SUB_BLOCKS > 1) ? $clog2(B_SUB_BLOCKS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WID_W-1:0] in_wid,
  input  logic [NT-1:0]    in_tmask,
  input  logic [3:0]       in_fmt_s,
  input  logic [3:0]       in_fmt_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WID_W-1:0] out_wid,
  output logic [NT-1:0]    out_tmask,
  output logic [3:0]       out_fmt_s,
  output logic [3:0]       out_fmt_d,
  output logic [MW-1:0]    out_step_m,
  output logic [NW-1:0]    out_step_n,
  output logic [KW-1:0]    out_step_k,
  output logic [4:0]       out_rs_a,
  output logic [4:0]       out_rs_b,
  output logic [4:0]       out_rd_c,
  output logic [SAW-1:0]   out_sub_a,
  output logic [SBW-1:0]   out_sub_b,
  output logic             out_first_k,
  output logic             out_last,
  output logic             busy
);

  // Sub-block counts are powers of two, so divide/modulo become shift/mask.
  localparam int A_SH = $clog2(A_SUB_BLOCKS);
  localparam int B_SH = $clog2(B_SUB_BLOCKS);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [NW-1:0]   n_q, n_d;
  logic [KW-1:0]   k_q, k_d;
  logic            latch_en;
  logic            hs;
  logic            m_end, n_end, k_end;
  logic [31:0]     a_idx, b_idx;

  assign m_end = (m_q == MW'(M_STEPS - 1));
  assign n_end = (n_q == NW'(N_STEPS - 1));
  assign k_end = (k_q == KW'(K_STEPS - 1));
  assign hs    = out_valid && out_ready;

  // Next-state and step-counter advance; counters only move on a handshake
  // so every field is held steady while downstream stalls.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          latch_en = 1'b1;
          m_d      = '0;
          n_d      = '0;
          k_d      = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          if (out_last) state_d = IDLE;
          if (k_end) begin
            k_d = '0;
            if (n_end) begin
              n_d = '0;
              m_d = m_end ? '0 : m_q + 1'b1;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and step counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

  // Instruction fields captured at accept and replayed on every micro-op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wid   <= '0;
      out_tmask <= '0;
      out_fmt_s <= '0;
      out_fmt_d <= '0;
    end else if (latch_en) begin
      out_wid   <= in_wid;
      out_tmask <= in_tmask;
      out_fmt_s <= in_fmt_s;
      out_fmt_d <= in_fmt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ISSUE);
  assign out_valid = (state_q == ISSUE);

  assign out_step_m = m_q;
  assign out_step_n = n_q;
  assign out_step_k = k_q;

  assign a_idx = 32'(m_q) * 32'(K_STEPS) + 32'(k_q);
  assign b_idx = 32'(n_q) * 32'(K_STEPS) + 32'(k_q);

  // Register numbers wrap within the 5-bit register file index.
  assign out_rs_a  = 5'(32'(RA) + (a_idx >> A_SH));
  assign out_rs_b  = 5'(32'(RB) + (b_idx >> B_SH));
  assign out_rd_c  = 5'(32'(RC) + 32'(m_q) * 32'(N_STEPS) + 32'(n_q));
  assign out_sub_a = SAW'(a_idx & 32'(A_SUB_BLOCKS - 1));
  assign out_sub_b = SBW'(b_idx & 32'(B_SUB_BLOCKS - 1));

  assign out_first_k = (k_q == '0);
  assign out_last    = m_end && n_end && k_end;

endmodule

// File: tb/tb_tcu_wmma_uop_sequencer.sv
// Directed bench for tcu_wmma_uop_sequencer: default geometry, a 1x1x1
// geometry, and a geometry with two A blocks per register and one B block.
module tb_tcu_wmma_uop_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [1:0] in_wid;
  logic [7:0] in_tmask;
  logic [3:0] in_fmt_s, in_fmt_d;

  // default instance
  logic d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_fk, d_last, d_busy;
  logic [1:0] d_wid; logic [7:0] d_tmask; logic [3:0] d_fs, d_fd;
  logic [0:0] d_m, d_sa, d_sb; logic [1:0] d_n, d_k; logic [4:0] d_ra, d_rb, d_rc;
  // 1x1x1 instance
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_fk, s_last, s_busy;
  logic [1:0] s_wid; logic [7:0] s_tmask; logic [3:0] s_fs, s_fd;
  logic [0:0] s_m, s_n, s_k, s_sa, s_sb; logic [4:0] s_ra, s_rb, s_rc;
  // A_SUB=2, B_SUB=1 instance
  logic h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_fk, h_last, h_busy;
  logic [1:0] h_wid; logic [7:0] h_tmask; logic [3:0] h_fs, h_fd;
  logic [0:0] h_m, h_sa, h_sb; logic [1:0] h_n, h_k; logic [4:0] h_ra, h_rb, h_rc;

  int n_vec = 0;
  int n_err = 0;

  tcu_wmma_uop_sequencer u_def (
    .clk(clk), .reset_n(reset_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_wid(in_wid), .in_tmask(in_tmask), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_wid(d_wid), .out_tmask(d_tmask),
    .out_fmt_s(d_fs), .out_fmt_d(d_fd), .out_step_m(d_m), .out_step_n(d_n), .out_step_k(d_k),
    .out_rs_a(d_ra), .out_rs_b(d_rb), .out_rd_c(d_rc), .out_sub_a(d_sa), .out_sub_b(d_sb),
    .out_first_k(d_fk), .out_last(d_last), .busy(d_busy));

  tcu_wmma_uop_sequencer #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1)) u_one (
    .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_wid(in_wid), .in_tmask(in_tmask), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_wid(s_wid), .out_tmask(s_tmask),
    .out_fmt_s(s_fs), .out_fmt_d(s_fd), .out_step_m(s_m), .out_step_n(s_n), .out_step_k(s_k),
    .out_rs_a(s_ra), .out_rs_b(s_rb), .out_rd_c(s_rc), .out_sub_a(s_sa), .out_sub_b(s_sb),
    .out_first_k(s_fk), .out_last(s_last), .busy(s_busy));

  tcu_wmma_uop_sequencer #(.A_SUB_BLOCKS(2), .B_SUB_BLOCKS(1)) u_half (
    .clk(clk), .reset_n(reset_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_wid(in_wid), .in_tmask(in_tmask), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_wid(h_wid), .out_tmask(h_tmask),
    .out_fmt_s(h_fs), .out_fmt_d(h_fd), .out_step_m(h_m), .out_step_n(h_n), .out_step_k(h_k),
    .out_rs_a(h_ra), .out_rs_b(h_rb), .out_rd_c(h_rc), .out_sub_a(h_sa), .out_sub_b(h_sb),
    .out_first_k(h_fk), .out_last(h_last), .busy(h_busy));

  // Packed uop fields: {m,n,k,rs_a,rs_b,rd_c,sub_a,sub_b,first_k,last}.
  function automatic logic [36:0] mk(int m, int n, int k, int ra, int rb, int rc,
                                     int sa, int sb, int fk, int ls);
    return {4'(m), 4'(n), 4'(k), 5'(ra), 5'(rb), 5'(rc), 4'(sa), 4'(sb), 1'(fk), 1'(ls)};
  endfunction

  // Expected uop number u for the given geometry (bases 0/10/24).
  function automatic logic [36:0] model(int u, int mm, int nn, int kk, int as, int bs);
    int m, n, k, a, b;
    k = u % kk;
    n = (u / kk) % nn;
    m = u / (kk * nn);
    a = m * kk + k;
    b = n * kk + k;
    return mk(m, n, k, a / as, 10 + b / bs, 24 + m * nn + n, a % as, b % bs,
              (k == 0) ? 1 : 0, (u == mm * nn * kk - 1) ? 1 : 0);
  endfunction

  function automatic logic [36:0] act_d();
    return {4'(d_m), 4'(d_n), 4'(d_k), d_ra, d_rb, d_rc, 4'(d_sa), 4'(d_sb), d_fk, d_last};
  endfunction
  function automatic logic [36:0] act_s();
    return {4'(s_m), 4'(s_n), 4'(s_k), s_ra, s_rb, s_rc, 4'(s_sa), 4'(s_sb), s_fk, s_last};
  endfunction
  function automatic logic [36:0] act_h();
    return {4'(h_m), 4'(h_n), 4'(h_k), h_ra, h_rb, h_rc, 4'(h_sa), 4'(h_sb), h_fk, h_last};
  endfunction

  // Present an instruction on one instance; returns 1 time unit after the accept edge.
  task automatic start(int which, logic [1:0] wid, logic [7:0] tm, logic [3:0] fs, logic [3:0] fd);
    @(negedge clk);
    in_wid = wid; in_tmask = tm; in_fmt_s = fs; in_fmt_d = fd;
    case (which)
      0: d_in_valid = 1'b1;
      1: s_in_valid = 1'b1;
      default: h_in_valid = 1'b1;
    endcase
    @(posedge clk);
    #1;
    d_in_valid = 1'b0; s_in_valid = 1'b0; h_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({d_in_ready, d_out_valid, d_busy} !== 3'b100) begin
      n_err++; $display("FAIL reset_def_flags got=%b exp=100", {d_in_ready, d_out_valid, d_busy});
    end
    n_vec++;
    if ({d_wid, d_tmask, d_fs, d_fd} !== 18'h0) begin
      n_err++; $display("FAIL reset_def_fields got=%h exp=0", {d_wid, d_tmask, d_fs, d_fd});
    end
    n_vec++;
    if ({s_in_ready, s_out_valid, h_in_ready, h_out_valid} !== 4'b1010) begin
      n_err++; $display("FAIL reset_other_flags got=%b exp=1010",
                        {s_in_ready, s_out_valid, h_in_ready, h_out_valid});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_default_seq();
    logic [36:0] a;
    start(0, 2'd1, 8'hA5, 4'd3, 4'd5);
    for (int u = 0; u < 32; u++) begin
      @(negedge clk);
      a = act_d();
      n_vec++;
      if ({d_out_valid, d_busy, d_in_ready} !== 3'b110) begin
        n_err++; $display("FAIL seq_flags u=%0d got=%b exp=110", u, {d_out_valid, d_busy, d_in_ready});
      end
      n_vec++;
      if (a !== model(u, 2, 4, 4, 1, 2)) begin
        n_err++; $display("FAIL seq_uop u=%0d got=%h exp=%h", u, a, model(u, 2, 4, 4, 1, 2));
      end
      if (u == 0) begin
        n_vec++;
        if (a !== mk(0, 0, 0, 0, 10, 24, 0, 0, 1, 0)) begin
          n_err++; $display("FAIL uop0 got=%h exp=%h", a, mk(0, 0, 0, 0, 10, 24, 0, 0, 1, 0));
        end
        n_vec++;
        if ({d_wid, d_tmask, d_fs, d_fd} !== {2'd1, 8'hA5, 4'd3, 4'd5}) begin
          n_err++; $display("FAIL latch got=%h exp=%h", {d_wid, d_tmask, d_fs, d_fd},
                            {2'd1, 8'hA5, 4'd3, 4'd5});
        end
      end
      if (u == 5) begin
        n_vec++;
        if (a !== mk(0, 1, 1, 1, 12, 25, 0, 1, 0, 0)) begin
          n_err++; $display("FAIL uop5 got=%h exp=%h", a, mk(0, 1, 1, 1, 12, 25, 0, 1, 0, 0));
        end
      end
      if (u == 31) begin
        n_vec++;
        if (a !== mk(1, 3, 3, 7, 17, 31, 0, 1, 0, 1)) begin
          n_err++; $display("FAIL uop31 got=%h exp=%h", a, mk(1, 3, 3, 7, 17, 31, 0, 1, 0, 1));
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if ({d_in_ready, d_out_valid, d_busy} !== 3'b100) begin
      n_err++; $display("FAIL seq_end got=%b exp=100", {d_in_ready, d_out_valid, d_busy});
    end
  endtask

  task automatic test_stall();
    logic [36:0] a, held;
    int cnt, cyc;
    logic prev_stall, r;
    cnt = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    start(0, 2'd2, 8'h0F, 4'd1, 4'd2);
    while (cnt < 32 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      a = act_d();
      n_vec++;
      if (d_out_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_valid cnt=%0d got=%b exp=1", cnt, d_out_valid);
        break;
      end
      if (prev_stall) begin
        n_vec++;
        if (a !== held) begin
          n_err++; $display("FAIL stall_hold cnt=%0d got=%h exp=%h", cnt, a, held);
        end
      end
      if (a !== model(cnt, 2, 4, 4, 1, 2)) begin
        n_err++; $display("FAIL stall_uop cnt=%0d got=%h exp=%h", cnt, a, model(cnt, 2, 4, 4, 1, 2));
      end
      r = 1'($urandom_range(0, 1));
      d_out_ready = r;
      held = a;
      prev_stall = ~r;
      if (r) cnt++;
    end
    n_vec++;
    if (cnt != 32) begin
      n_err++; $display("FAIL stall_count got=%0d exp=32", cnt);
    end
    @(negedge clk);
    d_out_ready = 1'b1;
    n_vec++;
    if ({d_out_valid, d_in_ready} !== 2'b01) begin
      n_err++; $display("FAIL stall_end got=%b exp=01", {d_out_valid, d_in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] a;
    start(0, 2'd1, 8'hA5, 4'd3, 4'd5);
    in_wid = 2'd2; in_tmask = 8'h3C; in_fmt_s = 4'd6; in_fmt_d = 4'd7;
    d_in_valid = 1'b1;
    for (int u = 0; u < 32; u++) begin
      @(negedge clk);
      a = act_d();
      n_vec++;
      if ({d_in_ready, d_wid, d_fs, d_fd} !== {1'b0, 2'd1, 4'd3, 4'd5}) begin
        n_err++; $display("FAIL b2b_hold u=%0d got=%h exp=%h", u, {d_in_ready, d_wid, d_fs, d_fd},
                          {1'b0, 2'd1, 4'd3, 4'd5});
      end
      if (a !== model(u, 2, 4, 4, 1, 2)) begin
        n_err++; $display("FAIL b2b_uop1 u=%0d got=%h exp=%h", u, a, model(u, 2, 4, 4, 1, 2));
      end
    end
    @(negedge clk);
    n_vec++;
    if ({d_in_ready, d_out_valid} !== 2'b10) begin
      n_err++; $display("FAIL b2b_bubble got=%b exp=10", {d_in_ready, d_out_valid});
    end
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    for (int u = 0; u < 32; u++) begin
      @(negedge clk);
      a = act_d();
      n_vec++;
      if ({d_out_valid, d_wid, d_tmask, d_fs, d_fd} !== {1'b1, 2'd2, 8'h3C, 4'd6, 4'd7}) begin
        n_err++; $display("FAIL b2b_fields u=%0d got=%h exp=%h", u,
                          {d_out_valid, d_wid, d_tmask, d_fs, d_fd}, {1'b1, 2'd2, 8'h3C, 4'd6, 4'd7});
      end
      if (a !== model(u, 2, 4, 4, 1, 2)) begin
        n_err++; $display("FAIL b2b_uop2 u=%0d got=%h exp=%h", u, a, model(u, 2, 4, 4, 1, 2));
      end
    end
    @(negedge clk);
    n_vec++;
    if ({d_in_ready, d_out_valid} !== 2'b10) begin
      n_err++; $display("FAIL b2b_end got=%b exp=10", {d_in_ready, d_out_valid});
    end
  endtask

  task automatic test_reset_abort();
    logic [36:0] a;
    start(0, 2'd3, 8'hFF, 4'd9, 4'd8);
    for (int u = 0; u < 10; u++) begin
      @(negedge clk);
      a = act_d();
      n_vec++;
      if (a !== model(u, 2, 4, 4, 1, 2)) begin
        n_err++; $display("FAIL abort_pre u=%0d got=%h exp=%h", u, a, model(u, 2, 4, 4, 1, 2));
      end
    end
    @(posedge clk);
    #2;
    n_vec++;
    if (d_out_valid !== 1'b1) begin
      n_err++; $display("FAIL abort_valid_before got=%b exp=1", d_out_valid);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({d_out_valid, d_busy, d_in_ready, d_wid} !== {3'b001, 2'd0}) begin
      n_err++; $display("FAIL abort_async got=%b exp=00100", {d_out_valid, d_busy, d_in_ready, d_wid});
    end
    @(negedge clk);
    reset_n = 1'b1;
    start(0, 2'd1, 8'h11, 4'd2, 4'd4);
    for (int u = 0; u < 4; u++) begin
      @(negedge clk);
      a = act_d();
      n_vec++;
      if (a !== model(u, 2, 4, 4, 1, 2)) begin
        n_err++; $display("FAIL abort_restart u=%0d got=%h exp=%h", u, a, model(u, 2, 4, 4, 1, 2));
      end
    end
    // drain the restarted instruction
    repeat (29) @(negedge clk);
    n_vec++;
    if (d_in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_drain got=%b exp=1", d_in_ready);
    end
  endtask

  task automatic test_single();
    start(1, 2'd2, 8'h80, 4'd1, 4'd1);
    @(negedge clk);
    n_vec++;
    if ({s_out_valid, s_busy, s_in_ready} !== 3'b110) begin
      n_err++; $display("FAIL one_flags got=%b exp=110", {s_out_valid, s_busy, s_in_ready});
    end
    n_vec++;
    if (act_s() !== mk(0, 0, 0, 0, 10, 24, 0, 0, 1, 1)) begin
      n_err++; $display("FAIL one_uop got=%h exp=%h", act_s(), mk(0, 0, 0, 0, 10, 24, 0, 0, 1, 1));
    end
    @(negedge clk);
    n_vec++;
    if ({s_out_valid, s_busy, s_in_ready} !== 3'b001) begin
      n_err++; $display("FAIL one_end got=%b exp=001", {s_out_valid, s_busy, s_in_ready});
    end
  endtask

  task automatic test_sub_a();
    logic [36:0] a;
    start(2, 2'd0, 8'h01, 4'd0, 4'd0);
    for (int u = 0; u < 32; u++) begin
      @(negedge clk);
      a = act_h();
      n_vec++;
      if (a !== model(u, 2, 4, 4, 2, 1) || h_out_valid !== 1'b1) begin
        n_err++; $display("FAIL suba_uop u=%0d got=%h exp=%h", u, a, model(u, 2, 4, 4, 2, 1));
      end
      if (u == 1) begin
        n_vec++;
        if (a !== mk(0, 0, 1, 0, 11, 24, 1, 0, 0, 0)) begin
          n_err++; $display("FAIL suba_u1 got=%h exp=%h", a, mk(0, 0, 1, 0, 11, 24, 1, 0, 0, 0));
        end
      end
      if (u == 2) begin
        n_vec++;
        if (a !== mk(0, 0, 2, 1, 12, 24, 0, 0, 0, 0)) begin
          n_err++; $display("FAIL suba_u2 got=%h exp=%h", a, mk(0, 0, 2, 1, 12, 24, 0, 0, 0, 0));
        end
      end
      if (u == 31) begin
        n_vec++;
        if (a !== mk(1, 3, 3, 3, 25, 31, 1, 0, 0, 1)) begin
          n_err++; $display("FAIL suba_u31 got=%h exp=%h", a, mk(1, 3, 3, 3, 25, 31, 1, 0, 0, 1));
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if ({h_out_valid, h_in_ready} !== 2'b01) begin
      n_err++; $display("FAIL suba_end got=%b exp=01", {h_out_valid, h_in_ready});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_wid = '0; in_tmask = '0; in_fmt_s = '0; in_fmt_d = '0;
    d_in_valid = 1'b0; s_in_valid = 1'b0; h_in_valid = 1'b0;
    d_out_ready = 1'b1; s_out_ready = 1'b1; h_out_ready = 1'b1;
    test_reset();
    test_default_seq();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_single();
    test_sub_a();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
